// File: rtl/wasm_const_encoder.sv
// Serialises a typed WebAssembly value into the bytes of the matching *.const
// instruction: optional opcode byte, then a signed LEB128 or raw little-endian IEEE immediate.
module wasm_const_encoder #(
    parameter int EMIT_OPCODE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in_value,
    input  logic [1:0]  in_type,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    localparam logic [1:0] TYPE_I32 = 2'd0;
    localparam logic [1:0] TYPE_I64 = 2'd1;
    localparam logic [1:0] TYPE_F32 = 2'd2;
    localparam logic [1:0] TYPE_F64 = 2'd3;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] OPCODE  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [63:0] v_q, v_d;
    logic [2:0]  cnt_q, cnt_d;

    logic               isFloat;
    logic [6:0]         lebBits;
    logic signed [63:0] vShift;
    logic               lebFinal;
    logic [7:0]         rawByte;
    logic               rawLast;
    logic [7:0]         opcodeByte;
    logic               outFire;

    // Float types occupy the upper half of the type encoding.
    assign isFloat  = type_q[1];
    assign lebBits  = v_q[6:0];
    assign vShift   = $signed(v_q) >>> 7;
    assign lebFinal = ((vShift == '0) && !lebBits[6]) || ((vShift == '1) && lebBits[6]);
    assign rawByte  = v_q[{cnt_q, 3'b000} +: 8];
    assign rawLast  = (type_q == TYPE_F32) ? (cnt_q == 3'd3) : (cnt_q == 3'd7);
    assign outFire  = out_valid && out_ready;

    always_comb begin
        case (type_q)
            TYPE_I32: opcodeByte = 8'h41;
            TYPE_I64: opcodeByte = 8'h42;
            TYPE_F32: opcodeByte = 8'h43;
            default:  opcodeByte = 8'h44;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            OPCODE: begin
                out_valid = 1'b1;
                out_byte  = opcodeByte;
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                if (isFloat) begin
                    out_byte = rawByte;
                    out_last = rawLast;
                end else begin
                    out_byte = {!lebFinal, lebBits};
                    out_last = lebFinal;
                end
            end
            default: ;
        endcase
    end

    // Integers shift the working register per byte; floats keep it and step the byte counter.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    type_d = in_type;
                    cnt_d  = 3'd0;
                    case (in_type)
                        TYPE_I32: v_d = {{32{in_value[31]}}, in_value[31:0]};
                        TYPE_F32: v_d = {32'd0, in_value[31:0]};
                        default:  v_d = in_value;
                    endcase
                    state_d = (EMIT_OPCODE != 0) ? OPCODE : PAYLOAD;
                end
            end
            OPCODE: begin
                if (outFire) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                if (outFire) begin
                    if (out_last) state_d = IDLE;
                    if (isFloat) cnt_d = cnt_q + 3'd1;
                    else         v_d   = vShift;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            type_q  <= TYPE_I32;
            v_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wasm_const_encoder.sv
// Self-checking bench for wasm_const_encoder: directed vectors plus randomized values and
// backpressure, compared against a plain-arithmetic LEB128 / little-endian reference model.
module tb_wasm_const_encoder;

    localparam logic [1:0] T_I32 = 2'd0;
    localparam logic [1:0] T_I64 = 2'd1;
    localparam logic [1:0] T_F32 = 2'd2;
    localparam logic [1:0] T_F64 = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_value = '0;
    logic [1:0]  in_type = '0;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic        sel = 1'b1;

    logic       inReady1, outValid1, outLast1;
    logic [7:0] outByte1;
    logic       inReady0, outValid0, outLast0;
    logic [7:0] outByte0;
    logic       obsReady, obsValid, obsLast;
    logic [7:0] obsByte;

    int checks = 0;
    int failures = 0;

    logic [7:0] expBytes[$];
    logic [7:0] gotBytes[$];
    logic       gotLast[$];
    int         lastCycles;
    int         stableErrs;
    bit         timedOut;
    logic       acceptReady, postReady, postValid;

    always #5 clk = ~clk;

    wasm_const_encoder #(.EMIT_OPCODE(1)) dutOp (
        .clk(clk), .reset(reset), .in_value(in_value), .in_type(in_type),
        .in_valid(inValid && sel), .in_ready(inReady1), .out_byte(outByte1),
        .out_valid(outValid1), .out_ready(outReady), .out_last(outLast1)
    );

    wasm_const_encoder #(.EMIT_OPCODE(0)) dutNoOp (
        .clk(clk), .reset(reset), .in_value(in_value), .in_type(in_type),
        .in_valid(inValid && !sel), .in_ready(inReady0), .out_byte(outByte0),
        .out_valid(outValid0), .out_ready(outReady), .out_last(outLast0)
    );

    assign obsReady = sel ? inReady1  : inReady0;
    assign obsValid = sel ? outValid1 : outValid0;
    assign obsLast  = sel ? outLast1  : outLast0;
    assign obsByte  = sel ? outByte1  : outByte0;

    // Reference model: textbook signed LEB128 on a 64-bit integer, raw little-endian for floats.
    function automatic void buildExpected(input logic [63:0] val, input logic [1:0] ty, input bit withOp);
        longint x;
        logic [7:0] b;
        bit more;
        int n;
        expBytes.delete();
        if (withOp) begin
            case (ty)
                T_I32: expBytes.push_back(8'h41);
                T_I64: expBytes.push_back(8'h42);
                T_F32: expBytes.push_back(8'h43);
                default: expBytes.push_back(8'h44);
            endcase
        end
        if (ty == T_I32 || ty == T_I64) begin
            if (ty == T_I32) x = longint'($signed(val[31:0]));
            else             x = longint'(val);
            do begin
                b = x[7:0] & 8'h7F;
                x = x >>> 7;
                more = !((x == 0 && !b[6]) || (x == -1 && b[6]));
                expBytes.push_back({more, b[6:0]});
            end while (more);
        end else begin
            n = (ty == T_F32) ? 4 : 8;
            for (int i = 0; i < n; i++) expBytes.push_back(val[8*i +: 8]);
        end
    endfunction

    // Drives one value into the selected encoder and collects the emitted bytes.
    task automatic applyStimulus(input bit s, input logic [63:0] val, input logic [1:0] ty, input bit rnd);
        int cycles;
        bit held;
        logic [7:0] heldByte;
        logic heldLast;
        gotBytes.delete();
        gotLast.delete();
        stableErrs = 0;
        timedOut = 1'b0;
        lastCycles = -1;
        postReady = 1'bx;
        postValid = 1'bx;
        @(negedge clk);
        sel = s;
        in_value = val;
        in_type = ty;
        inValid = 1'b1;
        outReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        in_value = {$urandom, $urandom};
        in_type = 2'($urandom_range(0, 3));
        acceptReady = obsReady;
        held = 1'b0;
        heldByte = '0;
        heldLast = 1'b0;
        cycles = 0;
        forever begin
            cycles++;
            if (held && (obsValid !== 1'b1 || obsByte !== heldByte || obsLast !== heldLast))
                stableErrs++;
            outReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (obsValid === 1'b1 && outReady) begin
                gotBytes.push_back(obsByte);
                gotLast.push_back(obsLast);
                held = 1'b0;
                if (obsLast === 1'b1 || gotBytes.size() > 12) begin
                    lastCycles = cycles;
                    @(negedge clk);
                    postReady = obsReady;
                    postValid = obsValid;
                    break;
                end
            end else begin
                held = (obsValid === 1'b1);
                heldByte = obsByte;
                heldLast = obsLast;
            end
            @(negedge clk);
            if (cycles > 300) begin
                timedOut = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (inReady1 !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", inReady1); end
        checks++;
        if (outValid1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid1); end
        checks++;
        if (outByte1 !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_byte got=%h exp=00", outByte1); end
        checks++;
        if (outLast1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last got=%b exp=0", outLast1); end
        checks++;
        if (inReady0 !== 1'b1 || outValid0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_noop got=%b%b exp=10", inReady0, outValid0);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_i32_basic();
        buildExpected(64'd3, T_I32, 1'b1);
        applyStimulus(1'b1, 64'd3, T_I32, 1'b0);
        checks++;
        if (timedOut || gotBytes.size() != expBytes.size()) begin
            failures++;
            $display("[TB] FAIL i32_3_len got=%0d exp=%0d timeout=%0b", gotBytes.size(), expBytes.size(), timedOut);
        end else begin
            for (int i = 0; i < expBytes.size(); i++) begin
                checks++;
                if (gotBytes[i] !== expBytes[i] || gotLast[i] !== 1'(i == expBytes.size() - 1)) begin
                    failures++;
                    $display("[TB] FAIL i32_3_byte%0d got=%h/%b exp=%h", i, gotBytes[i], gotLast[i], expBytes[i]);
                end
            end
        end
        checks++;
        if (acceptReady !== 1'b0) begin failures++; $display("[TB] FAIL i32_busy_ready got=%b exp=0", acceptReady); end
        checks++;
        if (lastCycles != 2) begin failures++; $display("[TB] FAIL i32_latency got=%0d exp=2", lastCycles); end
        checks++;
        if (postReady !== 1'b1 || postValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL i32_return_idle got=%b%b exp=10", postReady, postValid);
        end
    endtask

    task automatic test_i32_values();
        logic [63:0] vals[6];
        vals = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 64'hDEADBEEF_00000003,
                 64'h0000_0000_7FFF_FFFF, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFC0};
        foreach (vals[k]) begin
            buildExpected(vals[k], T_I32, 1'b1);
            applyStimulus(1'b1, vals[k], T_I32, 1'b0);
            checks++;
            if (timedOut || gotBytes.size() != expBytes.size()) begin
                failures++;
                $display("[TB] FAIL i32v%0d_len got=%0d exp=%0d timeout=%0b", k, gotBytes.size(), expBytes.size(), timedOut);
            end else begin
                for (int i = 0; i < expBytes.size(); i++) begin
                    checks++;
                    if (gotBytes[i] !== expBytes[i] || gotLast[i] !== 1'(i == expBytes.size() - 1)) begin
                        failures++;
                        $display("[TB] FAIL i32v%0d_byte%0d got=%h/%b exp=%h", k, i, gotBytes[i], gotLast[i], expBytes[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_i64_long();
        buildExpected(64'h8000_0000_0000_0000, T_I64, 1'b1);
        applyStimulus(1'b1, 64'h8000_0000_0000_0000, T_I64, 1'b0);
        checks++;
        if (timedOut || gotBytes.size() != 11) begin
            failures++;
            $display("[TB] FAIL i64_min_len got=%0d exp=11 timeout=%0b", gotBytes.size(), timedOut);
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (gotBytes[i] !== expBytes[i] || gotLast[i] !== 1'(i == 10)) begin
                    failures++;
                    $display("[TB] FAIL i64_min_byte%0d got=%h/%b exp=%h", i, gotBytes[i], gotLast[i], expBytes[i]);
                end
            end
        end
        checks++;
        if (lastCycles != 11) begin failures++; $display("[TB] FAIL i64_min_latency got=%0d exp=11", lastCycles); end
    endtask

    task automatic test_float();
        logic [63:0] vals[2];
        logic [1:0]  tys[2];
        vals = '{64'hCAFE_F00D_3F80_0000, 64'h3FF0_0000_0000_0000};
        tys  = '{T_F32, T_F64};
        for (int op = 1; op >= 0; op--) begin
            for (int k = 0; k < 2; k++) begin
                buildExpected(vals[k], tys[k], 1'(op));
                applyStimulus(1'(op), vals[k], tys[k], 1'b0);
                checks++;
                if (timedOut || gotBytes.size() != expBytes.size()) begin
                    failures++;
                    $display("[TB] FAIL float%0d_op%0d_len got=%0d exp=%0d timeout=%0b", k, op, gotBytes.size(), expBytes.size(), timedOut);
                end else begin
                    for (int i = 0; i < expBytes.size(); i++) begin
                        checks++;
                        if (gotBytes[i] !== expBytes[i] || gotLast[i] !== 1'(i == expBytes.size() - 1)) begin
                            failures++;
                            $display("[TB] FAIL float%0d_op%0d_byte%0d got=%h/%b exp=%h", k, op, i, gotBytes[i], gotLast[i], expBytes[i]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] vals[3];
        vals = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'h0123_4567_89AB_CDEF};
        foreach (vals[k]) begin
            buildExpected(vals[k], T_I64, 1'b1);
            applyStimulus(1'b1, vals[k], T_I64, 1'b1);
            checks++;
            if (stableErrs != 0) begin failures++; $display("[TB] FAIL bp%0d_stable got=%0d exp=0", k, stableErrs); end
            checks++;
            if (timedOut || gotBytes.size() != expBytes.size()) begin
                failures++;
                $display("[TB] FAIL bp%0d_len got=%0d exp=%0d timeout=%0b", k, gotBytes.size(), expBytes.size(), timedOut);
            end else begin
                for (int i = 0; i < expBytes.size(); i++) begin
                    checks++;
                    if (gotBytes[i] !== expBytes[i] || gotLast[i] !== 1'(i == expBytes.size() - 1)) begin
                        failures++;
                        $display("[TB] FAIL bp%0d_byte%0d got=%h/%b exp=%h", k, i, gotBytes[i], gotLast[i], expBytes[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        sel = 1'b1;
        outReady = 1'b1;
        in_value = 64'h8000_0000_0000_0000;
        in_type = T_I64;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (outValid1 !== 1'b0 || inReady1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_idle got=%b%b exp=01", outValid1, inReady1);
        end
        reset = 1'b1;
        buildExpected(64'd3, T_I32, 1'b1);
        applyStimulus(1'b1, 64'd3, T_I32, 1'b0);
        checks++;
        if (timedOut || gotBytes.size() != expBytes.size()) begin
            failures++;
            $display("[TB] FAIL midreset_len got=%0d exp=%0d timeout=%0b", gotBytes.size(), expBytes.size(), timedOut);
        end else begin
            for (int i = 0; i < expBytes.size(); i++) begin
                checks++;
                if (gotBytes[i] !== expBytes[i] || gotLast[i] !== 1'(i == expBytes.size() - 1)) begin
                    failures++;
                    $display("[TB] FAIL midreset_byte%0d got=%h/%b exp=%h", i, gotBytes[i], gotLast[i], expBytes[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] v;
        logic [1:0]  ty;
        bit s;
        for (int k = 0; k < 30; k++) begin
            v = {$urandom, $urandom};
            if (k % 3 == 0) v = v >> $urandom_range(0, 63);
            if (k % 5 == 1) v = ~v >> $urandom_range(40, 63);
            if (k % 7 == 2) v = ~(v >> $urandom_range(0, 63));
            ty = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            buildExpected(v, ty, s);
            applyStimulus(s, v, ty, 1'($urandom_range(0, 1)));
            checks++;
            if (stableErrs != 0 || timedOut || gotBytes.size() != expBytes.size()) begin
                failures++;
                $display("[TB] FAIL rnd%0d_len got=%0d exp=%0d stall_errs=%0d timeout=%0b", k, gotBytes.size(), expBytes.size(), stableErrs, timedOut);
            end else begin
                for (int i = 0; i < expBytes.size(); i++) begin
                    checks++;
                    if (gotBytes[i] !== expBytes[i] || gotLast[i] !== 1'(i == expBytes.size() - 1)) begin
                        failures++;
                        $display("[TB] FAIL rnd%0d_byte%0d got=%h/%b exp=%h (v=%h t=%0d)", k, i, gotBytes[i], gotLast[i], expBytes[i], v, ty);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_i32_basic();
        test_i32_values();
        test_i64_long();
        test_float();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
